alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the dual-read register file: consumes its two ALU read ports and the shared opcode, and produces the register write-back data and write-enable.
- Single-cycle logic/add ops plus iterative shift-add multiply and restoring divide, under a start/busy/done handshake driven by the control sequencer.
- Captures operands and opcode at start, so the register file read ports may change while this block is busy.

Parameters:
- DATA_WIDTH, 16, operand/result width; also the iteration count for MUL/DIV.
- ALU_OP_NIBBLE, 4'b0001, value of opcode[15:12] that marks an ALU instruction.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  16  shared instruction opcode; [15:12] class, [11:8] ALU function.
- start  in  1  one-cycle request; sampled only in IDLE.
- operand_a  in  DATA_WIDTH  from register file read_data_1.
- operand_b  in  DATA_WIDTH  from register file read_data_2.
- write_data  out  DATA_WIDTH  result to register file write_data.
- write_enable  out  1  one-cycle write-back pulse.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse, coincident with write_enable or error.
- flag_zero  out  1  result == 0, valid with done, held until the next done.
- flag_carry  out  1  carry/borrow out of ADD/SUB; 0 for other ops.
- error  out  1  one-cycle pulse on an illegal function or divide by zero.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; write_data, write_enable, busy, done, all flags and error = 0; accumulators cleared. Reset mid-operation aborts with no write-back.
- Accept: in IDLE, start=1 and opcode[15:12]==ALU_OP_NIBBLE latches opcode, operand_a and operand_b.
  - start with a non-ALU class: ignored; no done.
  - start while busy: ignored, not queued.
- Functions, opcode[11:8]:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL by b[3:0], 6 SHR (logical) by b[3:0].
  - 7 SLT: unsigned a<b gives 1, else 0.
  - 8 MUL: low DATA_WIDTH bits of the unsigned product.
  - 9 DIV: unsigned quotient. A Remainder.
  - B-F illegal.
- FSM:
  - IDLE: a single-cycle op goes to DONE; MUL/DIV/REM go to ITER with count=DATA_WIDTH-1; an illegal function goes to DONE with an error.
  - ITER: one bit per cycle; at count==0 go to DONE.
  - DONE: one cycle; pulse done and write_enable (or error instead of write_enable); return to IDLE.
- Latency, accept edge to done pulse:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV/REM: DATA_WIDTH+1 cycles.
  - Back-to-back: next start is accepted the cycle after done.
- Arithmetic:
  - All results are truncated to DATA_WIDTH.
  - ADD carry = bit DATA_WIDTH of a+b. SUB flag_carry = borrow (a<b).
  - Divide by zero (b==0 for DIV/REM): no ITER; DONE with error=1, write_enable=0, write_data=all ones.
- write_data holds the last result until the next done; it does not change while busy.

Optional Feature:
- HW_DIV_EN
  - Defined: DIV/REM implemented as above.
  - Undefined: functions 9/A are illegal (1-cycle error, no write-back) and the divider datapath is not synthesised; MUL is unaffected.

Decomposition:
- Shared package alu_pkg:
  - ALU_OP nibble.
  - Function codes (FN_ADD ... FN_REM).
  - FSM state typedef {IDLE, ITER, DONE}.
  - DATA_WIDTH default.
- Sub-module alu_iter_muldiv: shift-add multiplier / restoring divider with load, step and count; top level holds the FSM, single-cycle ops and flags.

Test Plan:
- Reset mid-MUL: assert reset_n=0 at iteration 5 -> all outputs 0, no write_enable; next ADD 3+4 gives write_data=0x0007 one cycle after start.
- ADD 0xFFFF+0x0001 -> write_data=0x0000, flag_zero=1, flag_carry=1, done/write_enable high exactly 1 cycle after start.
- MUL 0x0123*0x0010 -> 0x1230 after 17 cycles; busy high 16 cycles; a start pulse mid-operation is ignored.
- DIV 0x0064/0x0007 -> 0x000E; REM -> 0x0002; DIV by 0 -> error=1, write_enable=0, write_data=0xFFFF after 1 cycle.
- opcode 0x1B00 with start -> error pulse, no write_enable. opcode 0x2200 with start -> no done, busy stays 0.
- Operands change the cycle after a DIV start (0x00FF/0x0010 latched) -> result 0x000F is unaffected by the change.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU execute stage and its iterative multiply/divide unit.
// Optional divider hardware is selected with the HW_DIV_EN macro.
package alu_pkg;

  localparam int         DATA_WIDTH_DEF = 16;
  localparam logic [3:0] ALU_OP         = 4'b0001;

  typedef enum logic [3:0] {
    FN_ADD = 4'h0,
    FN_SUB = 4'h1,
    FN_AND = 4'h2,
    FN_OR  = 4'h3,
    FN_XOR = 4'h4,
    FN_SHL = 4'h5,
    FN_SHR = 4'h6,
    FN_SLT = 4'h7,
    FN_MUL = 4'h8,
    FN_DIV = 4'h9,
    FN_REM = 4'hA
  } alu_fn_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_mode_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// One-bit-per-step shift-add multiplier and restoring divider sharing a step counter.
// The divider datapath exists only when HW_DIV_EN is defined.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  step,
  input  md_mode_e              mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  last_step,
  output logic [DATA_WIDTH-1:0] res_next
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] partial;
  logic [DATA_WIDTH-1:0] mul_next;

  always_comb begin
    partial  = mplier_q[0] ? mcand_q : '0;
    mul_next = acc_q + partial;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load) begin
      count_d  = CW'(DATA_WIDTH - 1);
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (step) begin
      count_d  = count_q - 1'b1;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = mul_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign last_step = (count_q == '0);

`ifdef HW_DIV_EN
  md_mode_e              mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH:0]   diff;
  logic                  fits;
  logic [DATA_WIDTH-1:0] rem_step;
  logic [DATA_WIDTH-1:0] quo_step;

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  always_comb begin
    trial    = {rem_q, quo_q[DATA_WIDTH-1]};
    diff     = trial - {1'b0, dvsr_q};
    fits     = ~diff[DATA_WIDTH];
    rem_step = fits ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    quo_step = {quo_q[DATA_WIDTH-2:0], fits};
    mode_d   = mode_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    if (load) begin
      mode_d = mode;
      rem_d  = '0;
      quo_d  = a;
      dvsr_d = b;
    end else if (step) begin
      rem_d = rem_step;
      quo_d = quo_step;
    end
    case (mode_q)
      MD_DIV:  res_next = quo_step;
      MD_REM:  res_next = rem_step;
      default: res_next = mul_next;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MD_MUL;
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else begin
      mode_q <= mode_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign res_next    = mul_next;
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle logic/add ops plus iterative MUL (and DIV/REM when HW_DIV_EN
// is defined) behind a start/busy/done handshake, producing register write-back.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int         DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter logic [3:0] ALU_OP_NIBBLE = ALU_OP
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           opcode,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  error
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  write_enable_q, write_enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  flag_zero_q, flag_zero_d;
  logic                  flag_carry_q, flag_carry_d;
  logic                  error_q, error_d;

  logic [3:0]            fn;
  logic                  accept;
  logic [DATA_WIDTH:0]   alu_res;
  logic                  alu_single;
  logic                  iter_load;
  logic                  iter_step;
  logic                  iter_last;
  md_mode_e              iter_mode;
  logic [DATA_WIDTH-1:0] iter_res;
  logic                  unused_opcode_lo;

  assign fn               = opcode[11:8];
  assign accept           = start && (opcode[15:12] == ALU_OP_NIBBLE);
  assign unused_opcode_lo = ^opcode[7:0];

  // Bit DATA_WIDTH of alu_res is the carry/borrow; it stays 0 for every non-arithmetic op.
  always_comb begin
    alu_res    = '0;
    alu_single = 1'b1;
    case (fn)
      FN_ADD:  alu_res = {1'b0, operand_a} + {1'b0, operand_b};
      FN_SUB:  alu_res = {1'b0, operand_a} - {1'b0, operand_b};
      FN_AND:  alu_res = {1'b0, operand_a & operand_b};
      FN_OR:   alu_res = {1'b0, operand_a | operand_b};
      FN_XOR:  alu_res = {1'b0, operand_a ^ operand_b};
      FN_SHL:  alu_res = {1'b0, operand_a << operand_b[3:0]};
      FN_SHR:  alu_res = {1'b0, operand_a >> operand_b[3:0]};
      FN_SLT:  alu_res = {{DATA_WIDTH{1'b0}}, (operand_a < operand_b)};
      default: alu_single = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    write_data_d   = write_data_q;
    write_enable_d = 1'b0;
    done_d         = 1'b0;
    error_d        = 1'b0;
    flag_zero_d    = flag_zero_q;
    flag_carry_d   = flag_carry_q;
    iter_load      = 1'b0;
    iter_step      = 1'b0;
    iter_mode      = MD_MUL;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (alu_single) begin
            write_data_d   = alu_res[DATA_WIDTH-1:0];
            write_enable_d = 1'b1;
            flag_zero_d    = (alu_res[DATA_WIDTH-1:0] == '0);
            flag_carry_d   = alu_res[DATA_WIDTH];
          end else if (fn == FN_MUL) begin
            state_d   = ITER;
            done_d    = 1'b0;
            iter_load = 1'b1;
          end
`ifdef HW_DIV_EN
          else if ((fn == FN_DIV) || (fn == FN_REM)) begin
            if (operand_b == '0) begin
              write_data_d = '1;
              flag_zero_d  = 1'b0;
              flag_carry_d = 1'b0;
              error_d      = 1'b1;
            end else begin
              state_d   = ITER;
              done_d    = 1'b0;
              iter_load = 1'b1;
              iter_mode = (fn == FN_DIV) ? MD_DIV : MD_REM;
            end
          end
`endif
          else begin
            // Illegal function: report it, keep the previous result visible.
            error_d      = 1'b1;
            flag_carry_d = 1'b0;
          end
        end
      end
      ITER: begin
        iter_step = 1'b1;
        if (iter_last) begin
          state_d        = DONE;
          done_d         = 1'b1;
          write_enable_d = 1'b1;
          write_data_d   = iter_res;
          flag_zero_d    = (iter_res == '0);
          flag_carry_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == ITER);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      flag_zero_q    <= 1'b0;
      flag_carry_q   <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      write_data_q   <= write_data_d;
      write_enable_q <= write_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      flag_zero_q    <= flag_zero_d;
      flag_carry_q   <= flag_carry_d;
      error_q        <= error_d;
    end
  end

  alu_iter_muldiv #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (iter_load),
    .step      (iter_step),
    .mode      (iter_mode),
    .a         (operand_a),
    .b         (operand_b),
    .last_step (iter_last),
    .res_next  (iter_res)
  );

  assign write_data   = write_data_q;
  assign write_enable = write_enable_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign flag_zero    = flag_zero_q;
  assign flag_carry   = flag_carry_q;
  assign error        = error_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, hand-written reset and
// handshake sequences, and random ops checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_exec_stage;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [15:0]   opcode;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic          busy;
  logic          done;
  logic          flag_zero;
  logic          flag_carry;
  logic          error;

  alu_exec_stage #(
    .DATA_WIDTH    (DW),
    .ALU_OP_NIBBLE (4'b0001)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .start        (start),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .write_data   (write_data),
    .write_enable (write_enable),
    .busy         (busy),
    .done         (done),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        we;
    logic        err;
    logic        zero;
    logic        carry;
    logic        hold;   // result not updated: expect previous write_data / flag_zero
    logic        poke;   // pulse a second start while busy
    int          lat;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] last_wd = '0;
  logic        last_fz = 1'b0;
  vec_t        tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] data, input logic we, input logic err,
                              input logic zero, input logic carry, input logic hold,
                              input logic poke, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.data = data; v.we = we; v.err = err;
    v.zero = zero; v.carry = carry; v.hold = hold; v.poke = poke; v.lat = lat;
    return v;
  endfunction

  // Reference model: plain unsigned arithmetic on the operand values.
  function automatic vec_t model(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b);
    vec_t        v;
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned r  = 0;
    v = mk(op, a, b, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    case (op[11:8])
      4'd0: begin r = ua + ub; v.carry = (r > 32'hFFFF); end
      4'd1: begin r = ua - ub; v.carry = (ua < ub); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ua << (ub % 16);
      4'd6: r = ua >> (ub % 16);
      4'd7: r = (ua < ub) ? 1 : 0;
      4'd8: begin r = ua * ub; v.lat = 17; end
`ifdef HW_DIV_EN
      4'd9, 4'd10: begin
        if (ub == 0) begin
          r = 32'hFFFF; v.we = 1'b0; v.err = 1'b1;
        end else begin
          r = (op[11:8] == 4'd9) ? ua / ub : ua % ub;
          v.lat = 17;
        end
      end
`endif
      default: begin v.we = 1'b0; v.err = 1'b1; v.hold = 1'b1; end
    endcase
    v.data = r[15:0];
    v.zero = (v.data == 16'h0);
    return v;
  endfunction

  // Start one op; inputs are scrambled right after acceptance to prove they were captured.
  task automatic run_op(input logic [15:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic poke, output logic [15:0] wd, output logic we,
                        output logic err, output logic fz, output logic fc,
                        output int lat, output int bsy);
    @(negedge clk);
    opcode = op; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    opcode = 16'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom);
    lat = 1; bsy = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      if (poke && lat == 5) begin
        start = 1'b1; opcode = 16'h1000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    wd = write_data; we = write_enable; err = error; fz = flag_zero; fc = flag_carry;
    @(negedge clk);
    chk("done_pulse_width", {done, write_enable, error}, 3'b000);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] wd;
    logic        we, err, fz, fc;
    int          lat, bsy;
    logic [15:0] ed;
    logic        ez;
    run_op(v.op, v.a, v.b, v.poke, wd, we, err, fz, fc, lat, bsy);
    ed = v.hold ? last_wd : v.data;
    ez = v.hold ? last_fz : v.zero;
    $display("%s op=%h a=%h b=%h -> data=%h we=%b err=%b z=%b c=%b lat=%0d busy=%0d",
             tag, v.op, v.a, v.b, wd, we, err, fz, fc, lat, bsy);
    chk({tag, ".data"}, wd, ed);
    chk({tag, ".we"}, we, v.we);
    chk({tag, ".err"}, err, v.err);
    chk({tag, ".zero"}, fz, ez);
    chk({tag, ".carry"}, fc, v.carry);
    chk({tag, ".latency"}, lat, v.lat);
    chk({tag, ".busy_cycles"}, bsy, v.lat - 1);
    last_wd = ed;
    last_fz = ez;
  endtask

  task automatic no_class(input logic [15:0] op);
    int seen = 0;
    @(negedge clk);
    opcode = op; operand_a = 16'h1234; operand_b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen += int'(done | busy | write_enable | error);
      @(negedge clk);
    end
    $display("nonalu op=%h -> activity=%0d data=%h", op, seen, write_data);
    chk("nonalu.activity", seen, 0);
    chk("nonalu.data", write_data, last_wd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    chk("reset.write_data", write_data, 16'h0);
    chk("reset.write_enable", write_enable, 1'b0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.flag_zero", flag_zero, 1'b0);
    chk("reset.flag_carry", flag_carry, 1'b0);
    chk("reset.error", error, 1'b0);
    reset_n = 1'b1;

    // Reset in the middle of a multiply aborts it with no write-back.
    @(negedge clk);
    opcode = 16'h1800; operand_a = 16'h0123; operand_b = 16'h0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midmul.busy_before_reset", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midmul.outputs_after_reset",
        {write_data, write_enable, busy, done, flag_zero, flag_carry, error}, 22'h0);
    @(negedge clk);
    reset_n = 1'b1;
    last_wd = '0; last_fz = 1'b0;
    run_vec(mk(16'h1000, 16'h0003, 16'h0004, 16'h0007, 1, 0, 0, 0, 0, 0, 1), "post_reset_add");

    tbl.push_back(mk(16'h1000, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(16'h1100, 16'h0005, 16'h0007, 16'hFFFE, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(16'h1100, 16'h0007, 16'h0007, 16'h0000, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1200, 16'hF0F0, 16'h3C3C, 16'h3030, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1300, 16'hF0F0, 16'h0F01, 16'hFFF1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1400, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1500, 16'h0001, 16'h0013, 16'h0008, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1600, 16'h8000, 16'h000F, 16'h0001, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1700, 16'h0003, 16'h0004, 16'h0001, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1700, 16'h0004, 16'h0003, 16'h0000, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1800, 16'h0123, 16'h0010, 16'h1230, 1, 0, 0, 0, 0, 1, 17));
    tbl.push_back(mk(16'h1800, 16'hFFFF, 16'hFFFF, 16'h0001, 1, 0, 0, 0, 0, 0, 17));
`ifdef HW_DIV_EN
    tbl.push_back(mk(16'h1900, 16'h0064, 16'h0007, 16'h000E, 1, 0, 0, 0, 0, 0, 17));
    tbl.push_back(mk(16'h1A00, 16'h0064, 16'h0007, 16'h0002, 1, 0, 0, 0, 0, 0, 17));
    tbl.push_back(mk(16'h1900, 16'h0064, 16'h0000, 16'hFFFF, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(16'h1900, 16'h00FF, 16'h0010, 16'h000F, 1, 0, 0, 0, 0, 0, 17));
`else
    tbl.push_back(mk(16'h1900, 16'h0064, 16'h0007, 16'h0000, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(16'h1A00, 16'h0064, 16'h0007, 16'h0000, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(16'h1900, 16'h0064, 16'h0000, 16'h0000, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(16'h1900, 16'h00FF, 16'h0010, 16'h0000, 0, 1, 0, 0, 1, 0, 1));
`endif
    tbl.push_back(mk(16'h1B00, 16'h0001, 16'h0002, 16'h0000, 0, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(16'h1F00, 16'h0001, 16'h0002, 16'h0000, 0, 1, 0, 0, 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    no_class(16'h2200);
    no_class(16'h0800);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] op, a, b;
      op = {4'h1, 4'($urandom_range(0, 15)), 8'($urandom)};
      a  = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'h0000;
        1, 2:    b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      run_vec(model(op, a, b), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
